prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Self-synchronizing PRBS7 checker fed by the registered 1-bit decision from the
//  synchronous comparator stage (one received bit per clk).
//  Seeds its LFSR from the incoming stream, acquires lock, then free-runs and counts
//  bit errors for link BER measurement in the emulator.
//  Drops lock and re-seeds on an excessive error burst.
// PARAMETERS
//  CNT_W      32   width of err_count / bit_count (saturating)
//  LOCK_LEN   16   consecutive matches in ACQ needed to declare lock
//  WIN_LEN    256  LOCKED-mode bits per error-monitor window
//  UNLOCK_THR 16   window errors strictly above this -> lock lost
// PORTS
//  clk        in   1      sampling clock, same domain as comparator output
//  rst        in   1      synchronous, active-high reset
//  in         in   1      received bit (comparator decision), valid every cycle
//  clr        in   1      sync clear of err_count/bit_count; lock state untouched
//  locked     out  1      1 while FSM is in LOCKED
//  err        out  1      1-cycle pulse: previous bit mismatched prediction (LOCKED only)
//  err_count  out  CNT_W  errors counted in LOCKED, saturating at all-ones
//  bit_count  out  CNT_W  bits checked in LOCKED, saturating at all-ones
// BEHAVIOUR
//  - Sync reset (rst=1 at a clk edge): state=SEED, lfsr=0, seed_cnt=0, match_cnt=0,
//    win_cnt=0, win_err=0, locked=0, err=0, err_count=0, bit_count=0.
//    rst mid-operation aborts immediately and re-seeds from the next bit.
//  - LFSR s[6:0], polynomial x^7+x^6+1: pred = s[6]^s[5].
//    SEED/ACQ shift: s <= {s[5:0],in}. LOCKED shift: s <= {s[5:0],pred}.
//    Errors never corrupt the LOCKED predictor.
//  - SEED: shift in 7 bits (seed_cnt 0..6); after the 7th bit -> ACQ, match_cnt=0.
//  - ACQ: each bit compared to pred.
//    Match: match_cnt++; on the LOCK_LEN-th match -> LOCKED.
//    Mismatch: -> SEED, seed_cnt=0. No counting, err stays 0.
//  - LOCKED: err <= in^pred, registered, 1 cycle latency.
//    bit_count++ every bit; err_count++ on mismatch; both saturate.
//    win_cnt counts 0..WIN_LEN-1; win_err counts mismatches, saturating at UNLOCK_THR+1.
//  - Window end (bit with win_cnt==WIN_LEN-1, that bit's error included):
//    if win_err > UNLOCK_THR -> SEED and locked=0 next cycle; else stay LOCKED.
//    In both cases win_cnt=0 and win_err=0.
//  - locked is registered: it rises the cycle after the LOCK_LEN-th ACQ match and
//    falls the cycle after the failing window's last bit.
//  - Any transition into SEED: clears match/win counters; err_count/bit_count hold.
//  - clr=1: both counters become 0 next cycle. clr beats a same-cycle increment
//    (that bit is not counted). err pulse still reported.
//  - All-zero LFSR seed (bad stream): never matches a real PRBS; ACQ mismatch
//    returns to SEED. No lockup.
// STRUCTURE
//  - signal_package gains: PRBS7_ORDER=7, PRBS7_TAP_A=6, PRBS7_TAP_B=5,
//    typedef enum logic [1:0] {CHK_SEED, CHK_ACQ, CHK_LOCKED} prbs_chk_state_t.
//  - One sub-module: sat_counter #(W) (clk, rst, clr, inc, q); clr priority,
//    saturates at all-ones. Used for err_count and bit_count.
//  - FSM, LFSR and window logic live in prbs_checker; single always_ff + comb pred.
// TESTING
//  1. Clean PRBS7 from seed 7'h7F, LOCK_LEN=16: locked=1 on the cycle after input
//     bit #22 (0-based). 1000 further bits -> err_count=0, bit_count=1000, err never 1.
//  2. Locked; flip one bit -> single err pulse one cycle later, err_count=1.
//     Following bits are not flagged.
//  3. Locked; flip 17 bits within one 256-bit window -> locked=0 after that window
//     ends; relock 7+16 bits later on the clean stream. err_count holds 17 over relock.
//  4. Flip exactly 16 bits in one window -> lock retained, err_count=16.
//  5. ACQ mismatch at match #10 -> back to SEED; lock delayed by 7+16 bits from the
//     next bit. clr asserted on an error bit -> err_count=0, err pulse still seen.
//  6. rst pulse mid-LOCKED -> all outputs 0 next cycle; relock timing identical to (1).
//     CNT_W=4 run of 20 bits -> bit_count holds 4'hF.

Source files
------------

// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS7 checker: polynomial taps, FSM state type and
// the predictor helper.
package prbs_checker_pkg;

    localparam int PRBS7_ORDER = 7;
    localparam int PRBS7_TAP_A = 6;
    localparam int PRBS7_TAP_B = 5;

    typedef enum logic [1:0] {
        CHK_SEED   = 2'd0,
        CHK_ACQ    = 2'd1,
        CHK_LOCKED = 2'd2
    } prbs_chk_state_t;

    // Next PRBS7 bit (x^7+x^6+1) predicted from the current 7-bit history.
    function automatic logic prbs7_pred(input logic [PRBS7_ORDER-1:0] s);
        return s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Stream/status bundle between the bit source (master) and the PRBS7 checker (slave).
interface prbs_checker_if #(
    parameter int CNT_W = 32
);
    logic             i_in;
    logic             i_clr;
    logic             o_locked;
    logic             o_err;
    logic [CNT_W-1:0] o_err_count;
    logic [CNT_W-1:0] o_bit_count;

    modport master (
        output i_in, i_clr,
        input  o_locked, o_err, o_err_count, o_bit_count
    );

    modport slave (
        input  i_in, i_clr,
        output o_locked, o_err, o_err_count, o_bit_count
    );
endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Count register: reset, then clear, then increment until all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS7 checker: seeds from the stream, acquires lock, then
// free-runs and counts bit errors, dropping lock on an excessive error burst.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int LOCK_LEN   = 16,
    parameter int WIN_LEN    = 256,
    parameter int UNLOCK_THR = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    prbs_checker_if.slave bus
);

    localparam int SEED_W  = $clog2(PRBS7_ORDER);
    localparam int MATCH_W = $clog2(LOCK_LEN + 1);
    localparam int WIN_W   = $clog2(WIN_LEN);
    localparam int WERR_W  = $clog2(UNLOCK_THR + 2);

    prbs_chk_state_t        r_state;
    logic [PRBS7_ORDER-1:0] r_lfsr;
    logic [SEED_W-1:0]      r_seed_cnt;
    logic [MATCH_W-1:0]     r_match_cnt;
    logic [WIN_W-1:0]       r_win_cnt;
    logic [WERR_W-1:0]      r_win_err;
    logic                   r_locked;
    logic                   r_err;

    prbs_chk_state_t        w_next_state;
    logic [PRBS7_ORDER-1:0] w_lfsr_nxt;
    logic [SEED_W-1:0]      w_seed_cnt_nxt;
    logic [MATCH_W-1:0]     w_match_cnt_nxt;
    logic [WIN_W-1:0]       w_win_cnt_nxt;
    logic [WERR_W-1:0]      w_win_err_nxt;
    logic [WERR_W-1:0]      w_win_err_sum;
    logic                   w_err_nxt;
    logic                   w_bit_inc;
    logic                   w_err_inc;
    logic                   w_pred;
    logic                   w_mism;
    logic                   w_win_end;
    logic [CNT_W-1:0]       w_err_count;
    logic [CNT_W-1:0]       w_bit_count;

    assign w_pred    = prbs7_pred(r_lfsr);
    assign w_mism    = bus.i_in ^ w_pred;
    assign w_win_end = (r_win_cnt == WIN_W'(WIN_LEN - 1));
    // Window error tally including the current bit; sticks once past the threshold.
    assign w_win_err_sum = (w_mism && (r_win_err != WERR_W'(UNLOCK_THR + 1)))
                         ? (r_win_err + WERR_W'(1)) : r_win_err;

    // State register and all checker registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= CHK_SEED;
            r_lfsr      <= '0;
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_lfsr      <= w_lfsr_nxt;
            r_seed_cnt  <= w_seed_cnt_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_win_err   <= w_win_err_nxt;
            r_locked    <= (w_next_state == CHK_LOCKED);
            r_err       <= w_err_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CHK_SEED: begin
                if (r_seed_cnt == SEED_W'(PRBS7_ORDER - 1)) begin
                    w_next_state = CHK_ACQ;
                end else begin
                    w_next_state = CHK_SEED;
                end
            end
            CHK_ACQ: begin
                if (w_mism) begin
                    w_next_state = CHK_SEED;
                end else if (r_match_cnt == MATCH_W'(LOCK_LEN - 1)) begin
                    w_next_state = CHK_LOCKED;
                end else begin
                    w_next_state = CHK_ACQ;
                end
            end
            CHK_LOCKED: begin
                if (w_win_end && (w_win_err_sum > WERR_W'(UNLOCK_THR))) begin
                    w_next_state = CHK_SEED;
                end else begin
                    w_next_state = CHK_LOCKED;
                end
            end
            default: w_next_state = CHK_SEED;
        endcase
    end

    // Datapath next values; counters not owned by the next state fall back to zero.
    always_comb begin
        w_lfsr_nxt      = {r_lfsr[PRBS7_ORDER-2:0], bus.i_in};
        w_seed_cnt_nxt  = '0;
        w_match_cnt_nxt = '0;
        w_win_cnt_nxt   = '0;
        w_win_err_nxt   = '0;
        w_err_nxt       = 1'b0;
        w_bit_inc       = 1'b0;
        w_err_inc       = 1'b0;
        case (r_state)
            CHK_SEED: begin
                if (w_next_state == CHK_SEED) begin
                    w_seed_cnt_nxt = r_seed_cnt + SEED_W'(1);
                end else begin
                    w_seed_cnt_nxt = '0;
                end
            end
            CHK_ACQ: begin
                if (w_next_state == CHK_ACQ) begin
                    w_match_cnt_nxt = r_match_cnt + MATCH_W'(1);
                end else begin
                    w_match_cnt_nxt = '0;
                end
            end
            CHK_LOCKED: begin
                // Free-run on the prediction so received errors never reach the predictor.
                w_lfsr_nxt = {r_lfsr[PRBS7_ORDER-2:0], w_pred};
                w_err_nxt  = w_mism;
                w_bit_inc  = 1'b1;
                w_err_inc  = w_mism;
                if (w_win_end) begin
                    w_win_cnt_nxt = '0;
                    w_win_err_nxt = '0;
                end else begin
                    w_win_cnt_nxt = r_win_cnt + WIN_W'(1);
                    w_win_err_nxt = w_win_err_sum;
                end
            end
            default: w_lfsr_nxt = '0;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (bus.i_clr),
        .i_inc (w_err_inc),
        .o_q   (w_err_count)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (bus.i_clr),
        .i_inc (w_bit_inc),
        .o_q   (w_bit_count)
    );

    assign bus.o_locked    = r_locked;
    assign bus.o_err       = r_err;
    assign bus.o_err_count = w_err_count;
    assign bus.o_bit_count = w_bit_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed vector table, corner-case sequences and a
// randomized error/clear/reset run, all checked every cycle against a reference model.
module tb_prbs_checker;

    localparam int LOCK_LEN   = 16;
    localparam int WIN_LEN    = 256;
    localparam int UNLOCK_THR = 16;
    localparam int LOCK_BITS  = 7 + LOCK_LEN;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prbs_checker_if #(.CNT_W(32)) bus ();
    prbs_checker_if #(.CNT_W(4))  bus4 ();

    prbs_checker #(.CNT_W(32), .LOCK_LEN(LOCK_LEN), .WIN_LEN(WIN_LEN), .UNLOCK_THR(UNLOCK_THR)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    prbs_checker #(.CNT_W(4), .LOCK_LEN(LOCK_LEN), .WIN_LEN(WIN_LEN), .UNLOCK_THR(UNLOCK_THR)) dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmit stream: b[n] = b[n-7] ^ b[n-6], first 7 bits are the all-ones seed.
    bit tx[$];
    function automatic bit next_tx();
        bit b;
        if (tx.size() < 7) b = 1'b1;
        else               b = tx[tx.size()-7] ^ tx[tx.size()-6];
        tx.push_back(b);
        if (tx.size() > 7) void'(tx.pop_front());
        return b;
    endfunction

    // Reference model: bits-since-reseed phase counter plus a history of the
    // reference sequence (received bits while acquiring, predicted bits when locked).
    int     m_phase;
    bit     m_locked;
    bit     m_ref[$];
    int     m_wbits, m_werr;
    longint m_errs, m_bits;
    bit     m_err;

    task automatic model_step(input bit b, input bit c, input bit r);
        bit p, e, was_locked;
        if (r) begin
            m_phase = 0; m_locked = 0; m_wbits = 0; m_werr = 0;
            m_errs = 0; m_bits = 0; m_err = 0;
            m_ref.delete();
            for (int i = 0; i < 7; i++) m_ref.push_back(1'b0);
            return;
        end
        p = m_ref[m_ref.size()-7] ^ m_ref[m_ref.size()-6];
        e = 1'b0;
        was_locked = m_locked;
        m_err = 1'b0;
        if (!m_locked) begin
            m_ref.push_back(b);
            if (m_phase < 7) m_phase++;
            else if (b == p) begin
                m_phase++;
                if (m_phase == LOCK_BITS) begin
                    m_locked = 1; m_wbits = 0; m_werr = 0;
                end
            end else m_phase = 0;
        end else begin
            m_ref.push_back(p);
            e = b ^ p;
            m_err = e;
            m_wbits++;
            m_werr += int'(e);
            if (m_wbits == WIN_LEN) begin
                if (m_werr > UNLOCK_THR) begin
                    m_locked = 0; m_phase = 0;
                end
                m_wbits = 0; m_werr = 0;
            end
        end
        void'(m_ref.pop_front());
        if (c) begin
            m_errs = 0; m_bits = 0;
        end else if (was_locked) begin
            m_bits++;
            m_errs += longint'(e);
        end
    endtask

    function automatic logic [3:0] sat4(input longint v);
        return (v > 15) ? 4'hF : v[3:0];
    endfunction

    task automatic step(input bit b, input bit c, input bit r);
        logic [75:0] act, exp;
        bus.i_in = b; bus.i_clr = c; bus4.i_in = b; bus4.i_clr = c; rst = r;
        @(posedge clk);
        #1;
        model_step(b, c, r);
        exp = {m_locked, m_err, m_errs[31:0], m_bits[31:0], m_locked, m_err, sat4(m_errs), sat4(m_bits)};
        act = {bus.o_locked, bus.o_err, bus.o_err_count, bus.o_bit_count,
               bus4.o_locked, bus4.o_err, bus4.o_err_count, bus4.o_bit_count};
        check("cycle", {52'd0, act}, {52'd0, exp});
        bus.i_clr = 1'b0; bus4.i_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(next_tx(), 1'b0, 1'b0);
    endtask

    // Feed clean bits until lock; n = bits consumed, -1 if the bound expires.
    task automatic lock_count(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            step(next_tx(), 1'b0, 1'b0);
            if (bus.o_locked === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        int flips;
        int exp_errs;
        bit exp_locked;
    } vec_t;

    vec_t vecs[4];
    int   n, pulses, burst;
    bit   b, f, c, r;

    initial begin
        vecs[0] = '{0, 0, 1'b1};
        vecs[1] = '{1, 1, 1'b1};
        vecs[2] = '{16, 16, 1'b1};
        vecs[3] = '{17, 17, 1'b0};

        bus.i_in = 1'b0; bus.i_clr = 1'b0; bus4.i_in = 1'b0; bus4.i_clr = 1'b0; rst = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        check("reset_state", {bus.o_locked, bus.o_err, bus.o_err_count, bus.o_bit_count}, 66'd0);

        for (int i = 0; i < 4; i++) begin
            step(next_tx(), 1'b0, 1'b1);
            lock_count(n);
            check("lock_latency", n, LOCK_BITS);
            pulses = 0;
            for (int j = 0; j < WIN_LEN; j++) begin
                f = ((j % 10) == 5) && ((j / 10) < vecs[i].flips);
                step(next_tx() ^ f, 1'b0, 1'b0);
                pulses += int'(bus.o_err);
            end
            check("err_pulses", pulses, vecs[i].flips);
            check("window_err_count", bus.o_err_count, vecs[i].exp_errs);
            check("window_bit_count", bus.o_bit_count, WIN_LEN);
            check("locked_after_window", bus.o_locked, vecs[i].exp_locked);
            if (vecs[i].flips == 0) begin
                clean(1000 - WIN_LEN);
                check("clean_bit_count", bus.o_bit_count, 1000);
                check("clean_err_count", bus.o_err_count, 0);
            end
            if (!vecs[i].exp_locked) begin
                lock_count(n);
                check("relock_latency", n, LOCK_BITS);
                check("err_count_hold", bus.o_err_count, vecs[i].exp_errs);
            end
        end

        // ACQ mismatch on the 10th match attempt restarts seeding.
        step(next_tx(), 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(next_tx(), 1'b0, 1'b0);
        step(next_tx() ^ 1'b1, 1'b0, 1'b0);
        check("acq_fail_unlocked", {bus.o_locked, bus.o_err}, 2'b00);
        lock_count(n);
        check("acq_relock_latency", n, LOCK_BITS);

        // clr on an error bit wins over the increment, err pulse still reported.
        clean(5);
        step(next_tx() ^ 1'b1, 1'b1, 1'b0);
        check("clr_err_pulse", bus.o_err, 1'b1);
        check("clr_counts", {bus.o_err_count, bus.o_bit_count}, 64'd0);
        clean(1);
        check("post_clr_bit_count", bus.o_bit_count, 1);

        // Reset mid-LOCKED, then relock and saturate the narrow counters.
        step(next_tx(), 1'b0, 1'b1);
        check("mid_rst_outputs", {bus.o_locked, bus.o_err, bus.o_err_count, bus.o_bit_count}, 66'd0);
        lock_count(n);
        check("rst_relock_latency", n, LOCK_BITS);
        clean(20);
        check("bit_count_w32", bus.o_bit_count, 20);
        check("bit_count_w4_sat", bus4.o_bit_count, 4'hF);

        // Randomized errors, bursts, clears and resets against the model.
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) burst = 60;
            if (burst > 0) begin
                f = ($urandom_range(0, 2) == 0);
                burst--;
            end else begin
                f = ($urandom_range(0, 499) == 0);
            end
            c = ($urandom_range(0, 199) == 0);
            r = ($urandom_range(0, 999) == 0);
            b = next_tx() ^ f;
            step(b, c, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
